// File: rtl/prog_loader_if.sv
// Loader bus: byte-stream input with ready/valid, program RAM write port,
// and the download status flags.
interface prog_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  // Loader side: consumes the stream, drives memory and status.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );

  // Source side: byte producer and status observer.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO,
// payload, checksum. Payload bytes are written to program RAM one cycle after
// acceptance; done/error are sticky until the next SYNC.
module prog_loader #(
  parameter int              DATA_WIDTH = 8,
  parameter int              ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus
);

  localparam int LEN_W = 2 * DATA_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int HI_W  = ADDR_WIDTH - DATA_WIDTH;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, CSUM
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] lenhi_q, lenhi_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rdy_q;
  logic [LEN_W-1:0]      len;
  logic                  acc;

  assign acc = bus.rx_valid && rdy_q;

  // State and datapath registers; reset aborts any frame and drops a pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lenhi_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lenhi_q <= lenhi_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      rdy_q   <= 1'b1;
    end
  end

  // Frame parser: next state, running sum, write request and sticky flags.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lenhi_d = lenhi_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    len     = {lenhi_q, bus.rx_data};
    if (acc) begin
      // Every post-SYNC byte, checksum included, feeds the sum.
      sum_d = sum_q + bus.rx_data;
      unique case (state_q)
        IDLE: begin
          sum_d = sum_q;
          if (bus.rx_data == SYNC_BYTE) begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            sum_d   = '0;
            state_d = ADDR_HI;
          end
        end
        ADDR_HI: begin
          addr_d  = {bus.rx_data[HI_W-1:0], addr_q[DATA_WIDTH-1:0]};
          state_d = ADDR_LO;
        end
        ADDR_LO: begin
          addr_d  = {addr_q[ADDR_WIDTH-1:DATA_WIDTH], bus.rx_data};
          state_d = LEN_HI;
        end
        LEN_HI: begin
          lenhi_d = bus.rx_data;
          state_d = LEN_LO;
        end
        LEN_LO: begin
          if (len > MAX_LEN) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (len == '0) begin
            state_d = CSUM;
          end else begin
            cnt_d   = len[CNT_W-1:0];
            state_d = DATA;
          end
        end
        DATA: begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = bus.rx_data;
          addr_d  = addr_q + ADDR_WIDTH'(1);  // wraps modulo memory size
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = CSUM;
        end
        CSUM: begin
          if (sum_d == '0) done_d = 1'b1;
          else             err_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = rdy_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_hold  = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames with expected writes and flags,
// write scoreboard checked by a negedge monitor, plus a mid-frame reset sequence.
module tb_prog_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  prog_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) bus ();

  prog_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [95:0] bytes;   // right-aligned, first byte most significant
    int          n;
    int          gap;
    int          nw;
    int          didx;    // index of first payload byte
    logic [11:0] wa0, wa1;
    logic [7:0]  wd0, wd1;
    logic        edone, eerr;
  } vec_t;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t  sb[$];
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every write strobe must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {8'h0, bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
        chk("wr_data", 32'(bus.mem_wdata), 32'(e.d));
        chk("wr_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit push,
                           input logic [11:0] a, input logic [7:0] d);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    chk("rx_ready", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    if (push) begin
      wr_t w;
      w.a = a; w.d = d; w.c = cyc;
      sb.push_back(w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    for (int i = 0; i < v.n; i++) begin
      logic [7:0] b;
      bit         p;
      b = v.bytes[(v.n-1-i)*8 +: 8];
      p = (i >= v.didx) && (i < v.didx + v.nw);
      send_byte(b, p, (i == v.didx) ? v.wa0 : v.wa1, (i == v.didx) ? v.wd0 : v.wd1);
      if (v.gap > 0) idle(v.gap);
    end
    idle(2);
    chk($sformatf("v%0d_done", id), 32'(bus.done), 32'(v.edone));
    chk($sformatf("v%0d_error", id), 32'(bus.error), 32'(v.eerr));
    chk($sformatf("v%0d_busy", id), 32'(bus.busy), 32'd0);
    chk($sformatf("v%0d_hold", id), 32'(bus.cpu_hold), 32'd0);
    chk($sformatf("v%0d_sb_empty", id), 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Noise then zero-length frame: 0x01+0xFF sums to zero.
    tbl[0] = '{96'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF}),
               9, 0, 0, 0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b1, 1'b0};
    tbl[1] = '{96'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h3C, 8'h7E, 8'h34}),
               8, 0, 2, 5, 12'h010, 12'h011, 8'h3C, 8'h7E, 1'b1, 1'b0};
    tbl[2] = '{96'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h3C, 8'h7E, 8'h35}),
               8, 0, 2, 5, 12'h010, 12'h011, 8'h3C, 8'h7E, 1'b0, 1'b1};
    // Good frame with 3-cycle valid gaps; also clears the previous error.
    tbl[3] = '{96'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h3C, 8'h7E, 8'h34}),
               8, 3, 2, 5, 12'h010, 12'h011, 8'h3C, 8'h7E, 1'b1, 1'b0};
    // Address wrap. Sum of 0F FF 00 02 11 22 is 0x43, so the closing byte is 0xBD.
    tbl[4] = '{96'({8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBD}),
               8, 0, 2, 5, 12'hFFF, 12'h000, 8'h11, 8'h22, 1'b1, 1'b0};
    // Length 0x1001 > 4096; trailing 0x3C lands in IDLE and must not write.
    tbl[5] = '{96'({8'hA5, 8'h00, 8'h00, 8'h10, 8'h01, 8'h3C}),
               6, 0, 0, 0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b1};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_release", 32'(bus.rx_ready), 32'd1);

    for (int k = 0; k < 6; k++) run_vec(tbl[k], k);

    // Bad length flags error right after LEN_LO, with no writes.
    send_byte(8'hA5, 1'b0, 12'h0, 8'h0);
    send_byte(8'h00, 1'b0, 12'h0, 8'h0);
    send_byte(8'h00, 1'b0, 12'h0, 8'h0);
    send_byte(8'hFF, 1'b0, 12'h0, 8'h0);
    send_byte(8'hFF, 1'b0, 12'h0, 8'h0);
    chk("badlen_error_now", 32'(bus.error), 32'd1);
    chk("badlen_busy_now", 32'(bus.busy), 32'd0);
    chk("badlen_no_we", 32'(bus.mem_we), 32'd0);

    // Mid-frame reset: the pending write of the first payload byte is dropped.
    send_byte(8'hA5, 1'b0, 12'h0, 8'h0);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_hold", 32'(bus.cpu_hold), 32'd1);
    chk("mid_error_cleared", 32'(bus.error), 32'd0);
    send_byte(8'h00, 1'b0, 12'h0, 8'h0);
    send_byte(8'h20, 1'b0, 12'h0, 8'h0);
    send_byte(8'h00, 1'b0, 12'h0, 8'h0);
    send_byte(8'h02, 1'b0, 12'h0, 8'h0);
    send_byte(8'h3C, 1'b0, 12'h0, 8'h0);
    reset = 1'b1;
    #1;
    chk_reset_state("midrst");
    idle(2);
    chk_reset_state("midrst_hold");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_vec(tbl[1], 6);

    idle(3);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
